// File: rtl/regset_arbiter.sv
// regset_arbiter: two-requester round-robin arbiter and sequencer for the
// 8x4 register set. One transaction takes three clocks: grant (IDLE->ACCESS),
// regset access on the intervening negedge (ACCESS->DONE), release (DONE->IDLE).
// All outputs come straight from registers.
module regset_arbiter #(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input  logic          Clk,
    input  logic          Rst_n,
    // port A
    input  logic          Req_A,
    input  logic          RW_A,
    input  logic [AW-1:0] Addr_A,
    input  logic [DW-1:0] Wdata_A,
    output logic          Gnt_A,
    output logic          Done_A,
    output logic [DW-1:0] Rdata_A,
    // port B
    input  logic          Req_B,
    input  logic          RW_B,
    input  logic [AW-1:0] Addr_B,
    input  logic [DW-1:0] Wdata_B,
    output logic          Gnt_B,
    output logic          Done_B,
    output logic [DW-1:0] Rdata_B,
    // status
    output logic          Busy,
    // regset side
    output logic [AW-1:0] Rs_Address,
    output logic          Rs_RW,
    output logic [DW-1:0] Rs_Data_in,
    input  logic [DW-1:0] Rs_Data_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Port identifiers used for owner/last tracking
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t        state_q,   state_d;
    logic          owner_q,   owner_d;
    logic          last_q,    last_d;
    logic          op_wr_q,   op_wr_d;
    logic [AW-1:0] rs_addr_q, rs_addr_d;
    logic          rs_rw_q,   rs_rw_d;
    logic [DW-1:0] rs_din_q,  rs_din_d;
    logic          gnt_a_q,   gnt_a_d;
    logic          gnt_b_q,   gnt_b_d;
    logic          done_a_q,  done_a_d;
    logic          done_b_q,  done_b_d;
    logic [DW-1:0] rdata_a_q, rdata_a_d;
    logic [DW-1:0] rdata_b_q, rdata_b_d;
    logic          busy_q,    busy_d;

    logic          pick_b;

    // State and output registers; reset leaves Last = B so A wins the first tie
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            owner_q   <= PORT_A;
            last_q    <= PORT_B;
            op_wr_q   <= 1'b0;
            rs_addr_q <= '0;
            rs_rw_q   <= 1'b0;
            rs_din_q  <= '0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            op_wr_q   <= op_wr_d;
            rs_addr_q <= rs_addr_d;
            rs_rw_q   <= rs_rw_d;
            rs_din_q  <= rs_din_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and next-output logic; Rs_RW defaults low so it can only be
    // high for the single ACCESS cycle that follows a write grant
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        op_wr_d   = op_wr_q;
        rs_addr_d = rs_addr_q;
        rs_rw_d   = 1'b0;
        rs_din_d  = rs_din_q;
        gnt_a_d   = gnt_a_q;
        gnt_b_d   = gnt_b_q;
        done_a_d  = done_a_q;
        done_b_d  = done_b_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        pick_b    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Req_A || Req_B) begin
                    // B wins when it is alone, or on a tie when A was served last
                    pick_b    = Req_B && (!Req_A || (last_q == PORT_A));
                    owner_d   = pick_b ? PORT_B : PORT_A;
                    last_d    = pick_b ? PORT_B : PORT_A;
                    op_wr_d   = pick_b ? RW_B    : RW_A;
                    rs_addr_d = pick_b ? Addr_B  : Addr_A;
                    rs_din_d  = pick_b ? Wdata_B : Wdata_A;
                    rs_rw_d   = pick_b ? RW_B    : RW_A;
                    gnt_a_d   = !pick_b;
                    gnt_b_d   = pick_b;
                    state_d   = S_ACCESS;
                end
            end

            S_ACCESS: begin
                // The regset acted on the negedge inside this cycle. Read data
                // is captured only for reads; after a write Data_out is Z.
                if (owner_q == PORT_B) begin
                    done_b_d = 1'b1;
                    if (!op_wr_q) rdata_b_d = Rs_Data_out;
                end else begin
                    done_a_d = 1'b1;
                    if (!op_wr_q) rdata_a_d = Rs_Data_out;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                done_a_d = 1'b0;
                done_b_d = 1'b0;
                gnt_a_d  = 1'b0;
                gnt_b_d  = 1'b0;
                state_d  = S_IDLE;
            end

            default: begin
                gnt_a_d  = 1'b0;
                gnt_b_d  = 1'b0;
                done_a_d = 1'b0;
                done_b_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign Gnt_A      = gnt_a_q;
    assign Gnt_B      = gnt_b_q;
    assign Done_A     = done_a_q;
    assign Done_B     = done_b_q;
    assign Rdata_A    = rdata_a_q;
    assign Rdata_B    = rdata_b_q;
    assign Busy       = busy_q;
    assign Rs_Address = rs_addr_q;
    assign Rs_RW      = rs_rw_q;
    assign Rs_Data_in = rs_din_q;

endmodule

// File: tb/tb_regset_arbiter.sv
// Bench for regset_arbiter: behavioural 8x4 regset on the negedge, a
// transaction-level reference model (round-robin order, shadow memory,
// per-port read data) and randomized plus directed scenarios.
module tb_regset_arbiter;
    localparam int DW = 4;
    localparam int AW = 3;

    logic          Clk, Rst_n;
    logic          Req_A, RW_A, Req_B, RW_B;
    logic [AW-1:0] Addr_A, Addr_B;
    logic [DW-1:0] Wdata_A, Wdata_B;
    logic          Gnt_A, Done_A, Gnt_B, Done_B, Busy, Rs_RW;
    logic [DW-1:0] Rdata_A, Rdata_B, Rs_Data_in, Rs_Data_out;
    logic [AW-1:0] Rs_Address;

    int n_cmp = 0;
    int n_err = 0;

    regset_arbiter #(.DW(DW), .AW(AW)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Req_A(Req_A), .RW_A(RW_A), .Addr_A(Addr_A), .Wdata_A(Wdata_A),
        .Gnt_A(Gnt_A), .Done_A(Done_A), .Rdata_A(Rdata_A),
        .Req_B(Req_B), .RW_B(RW_B), .Addr_B(Addr_B), .Wdata_B(Wdata_B),
        .Gnt_B(Gnt_B), .Done_B(Done_B), .Rdata_B(Rdata_B),
        .Busy(Busy), .Rs_Address(Rs_Address), .Rs_RW(Rs_RW),
        .Rs_Data_in(Rs_Data_in), .Rs_Data_out(Rs_Data_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural regset: acts on the negedge, Data_out floats after a write
    logic [DW-1:0] rs_mem [8] = '{default: '0};
    always @(negedge Clk) begin
        if (Rs_RW) begin
            rs_mem[Rs_Address] <= Rs_Data_in;
            Rs_Data_out        <= 'z;
        end else begin
            Rs_Data_out <= rs_mem[Rs_Address];
        end
    end

    // Reference model: memory contents, per-port read data, last served port
    logic [DW-1:0] shadow [8];
    logic [DW-1:0] m_rd   [2];
    bit            m_last;
    int            e_gc   [2];
    int            e_dc   [2];

    // Results of the most recent run_txns
    int r_gc [2];
    int r_dc [2];
    bit r_ovl;

    function automatic void m_reset();
        m_last  = 1'b1;
        m_rd[0] = '0;
        m_rd[1] = '0;
    endfunction

    function automatic void m_apply(bit p, bit rw, logic [AW-1:0] a, logic [DW-1:0] d);
        if (rw) shadow[a] = d;
        else    m_rd[p]   = shadow[a];
        m_last = p;
    endfunction

    // Expected grant/done cycles (counted in edges from the request) and data effects
    function automatic void m_txns(bit ra, bit rb, bit rwa, bit rwb,
                                   logic [AW-1:0] aa, logic [AW-1:0] ab,
                                   logic [DW-1:0] wa, logic [DW-1:0] wb);
        bit first, second;
        e_gc[0] = -1; e_gc[1] = -1; e_dc[0] = -1; e_dc[1] = -1;
        first  = (ra && rb) ? !m_last : rb;
        second = !first;
        e_gc[first] = 1; e_dc[first] = 2;
        if (first) m_apply(1'b1, rwb, ab, wb);
        else       m_apply(1'b0, rwa, aa, wa);
        if (ra && rb) begin
            e_gc[second] = 4; e_dc[second] = 5;
            if (second) m_apply(1'b1, rwb, ab, wb);
            else        m_apply(1'b0, rwa, aa, wa);
        end
    endfunction

    // Drive one or two requests, hold each until its Done, then settle in IDLE.
    // The granted port's Addr/RW/Wdata are scrambled to show they are ignored.
    task automatic run_txns(input bit ra, input bit rb, input bit rwa, input bit rwb,
                            input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                            input logic [DW-1:0] wa, input logic [DW-1:0] wb);
        bit pa, pb;
        int cyc;
        r_gc[0] = -1; r_gc[1] = -1; r_dc[0] = -1; r_dc[1] = -1; r_ovl = 1'b0;
        Req_A = ra; RW_A = rwa; Addr_A = aa; Wdata_A = wa;
        Req_B = rb; RW_B = rwb; Addr_B = ab; Wdata_B = wb;
        pa = ra; pb = rb; cyc = 0;
        while ((pa || pb) && cyc < 20) begin
            @(posedge Clk); #1;
            cyc++;
            if (Gnt_A && Gnt_B) r_ovl = 1'b1;
            if (Gnt_A && r_gc[0] < 0) r_gc[0] = cyc;
            if (Gnt_B && r_gc[1] < 0) r_gc[1] = cyc;
            if (Done_A && pa) begin r_dc[0] = cyc; pa = 1'b0; Req_A = 1'b0; end
            if (Done_B && pb) begin r_dc[1] = cyc; pb = 1'b0; Req_B = 1'b0; end
            if (Gnt_A) begin Addr_A = AW'($urandom); Wdata_A = DW'($urandom); RW_A = 1'($urandom); end
            if (Gnt_B) begin Addr_B = AW'($urandom); Wdata_B = DW'($urandom); RW_B = 1'($urandom); end
        end
        Req_A = 1'b0; Req_B = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        #2;
        Rst_n = 1'b1;
        m_reset();
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Req_A = 0; RW_A = 0; Addr_A = '0; Wdata_A = '0;
        Req_B = 0; RW_B = 0; Addr_B = '0; Wdata_B = '0;
        Rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({Gnt_A, Gnt_B, Done_A, Done_B, Busy, Rs_RW} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 000000", {Gnt_A, Gnt_B, Done_A, Done_B, Busy, Rs_RW});
        end
        n_cmp++;
        if ({Rs_Address, Rs_Data_in, Rdata_A, Rdata_B} !== '0) begin
            n_err++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", Rs_Address, Rs_Data_in, Rdata_A, Rdata_B);
        end
        @(negedge Clk); Rst_n = 1'b1; m_reset();
        @(posedge Clk); #1;
        n_cmp++;
        if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: Busy got %b want 0", Busy); end

        // Reset in the middle of a write ACCESS cycle
        Req_A = 1; RW_A = 1; Addr_A = 3'd5; Wdata_A = 4'hF;
        @(posedge Clk); #1;
        n_cmp++;
        if (!(Gnt_A === 1'b1 && Rs_RW === 1'b1)) begin
            n_err++; $display("FAIL reset_pre_access: Gnt_A/Rs_RW got %b%b want 11", Gnt_A, Rs_RW);
        end
        #1 Rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({Rs_RW, Gnt_A, Gnt_B, Done_A, Done_B, Busy} !== 6'b0) begin
            n_err++; $display("FAIL reset_mid_access: got %b want 000000", {Rs_RW, Gnt_A, Gnt_B, Done_A, Done_B, Busy});
        end
        Req_A = 0;
        @(negedge Clk); #1 Rst_n = 1'b1; m_reset();
        @(posedge Clk); #1;
        n_cmp++;
        if ({Busy, Gnt_A, Done_A} !== 3'b0) begin
            n_err++; $display("FAIL reset_release_idle: got %b want 000", {Busy, Gnt_A, Done_A});
        end
    endtask

    task automatic test_write_read();
        run_txns(1, 0, 1, 0, 3'd3, 3'd0, 4'hA, 4'h0);
        m_txns(1, 0, 1, 0, 3'd3, 3'd0, 4'hA, 4'h0);
        n_cmp++;
        if (r_gc[0] !== e_gc[0] || r_dc[0] !== e_dc[0]) begin
            n_err++; $display("FAIL wr_latency: gnt/done cyc got %0d/%0d want %0d/%0d", r_gc[0], r_dc[0], e_gc[0], e_dc[0]);
        end
        run_txns(1, 0, 0, 0, 3'd3, 3'd0, 4'h0, 4'h0);
        m_txns(1, 0, 0, 0, 3'd3, 3'd0, 4'h0, 4'h0);
        n_cmp++;
        if (r_gc[0] !== e_gc[0] || r_dc[0] !== e_dc[0]) begin
            n_err++; $display("FAIL rd_latency: gnt/done cyc got %0d/%0d want %0d/%0d", r_gc[0], r_dc[0], e_gc[0], e_dc[0]);
        end
        n_cmp++;
        if (Rdata_A !== 4'hA) begin n_err++; $display("FAIL rd_back_A: got %h want a", Rdata_A); end
    endtask

    task automatic test_tie();
        logic [AW-1:0] aa, ab;
        do_reset();
        aa = AW'($urandom); ab = AW'($urandom);
        run_txns(1, 1, 0, 0, aa, ab, 4'h0, 4'h0);
        m_txns(1, 1, 0, 0, aa, ab, 4'h0, 4'h0);
        n_cmp++;
        if (r_gc[0] !== 1 || r_gc[1] !== 4) begin
            n_err++; $display("FAIL tie_order: gnt cyc A/B got %0d/%0d want 1/4", r_gc[0], r_gc[1]);
        end
        n_cmp++;
        if (r_dc[0] !== e_dc[0] || r_dc[1] !== e_dc[1]) begin
            n_err++; $display("FAIL tie_done: done cyc A/B got %0d/%0d want %0d/%0d", r_dc[0], r_dc[1], e_dc[0], e_dc[1]);
        end
        n_cmp++;
        if (r_ovl !== 1'b0) begin n_err++; $display("FAIL tie_overlap: got %b want 0", r_ovl); end
        n_cmp++;
        if (Rdata_A !== m_rd[0] || Rdata_B !== m_rd[1]) begin
            n_err++; $display("FAIL tie_rdata: got %h/%h want %h/%h", Rdata_A, Rdata_B, m_rd[0], m_rd[1]);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc, cnt, prev;
        bit   ovl, exp_p;
        bit   port [6];
        int   when [6];
        logic [AW-1:0] aa, ab;
        aa = AW'($urandom); ab = AW'($urandom);
        Req_A = 1; RW_A = 0; Addr_A = aa;
        Req_B = 1; RW_B = 0; Addr_B = ab;
        cyc = 0; cnt = 0; ovl = 0;
        while (cnt < 6 && cyc < 40) begin
            @(posedge Clk); #1;
            cyc++;
            if (Gnt_A && Gnt_B) ovl = 1;
            if (Done_A || Done_B) begin
                port[cnt] = Done_B;
                when[cnt] = cyc;
                cnt++;
                if (cnt == 6) begin Req_A = 0; Req_B = 0; end
            end
        end
        Req_A = 0; Req_B = 0;
        @(posedge Clk); #1;
        n_cmp++;
        if (cnt !== 6) begin n_err++; $display("FAIL b2b_count: got %0d want 6", cnt); end
        exp_p = !m_last;
        prev  = -1;
        for (int k = 0; k < cnt; k++) begin
            n_cmp++;
            if (port[k] !== exp_p) begin
                n_err++; $display("FAIL b2b_port%0d: got %0d want %0d", k, port[k], exp_p);
            end
            if (prev >= 0) begin
                n_cmp++;
                if (when[k] - prev !== 3) begin
                    n_err++; $display("FAIL b2b_spacing%0d: got %0d want 3", k, when[k] - prev);
                end
            end
            m_apply(exp_p, 1'b0, exp_p ? ab : aa, '0);
            prev  = when[k];
            exp_p = !exp_p;
        end
        n_cmp++;
        if (ovl !== 1'b0) begin n_err++; $display("FAIL b2b_overlap: got %b want 0", ovl); end
        n_cmp++;
        if (Rdata_A !== m_rd[0] || Rdata_B !== m_rd[1]) begin
            n_err++; $display("FAIL b2b_rdata: got %h/%h want %h/%h", Rdata_A, Rdata_B, m_rd[0], m_rd[1]);
        end
    endtask

    task automatic test_owner_isolation();
        logic [DW-1:0] sa, sb;
        sb = Rdata_B;
        run_txns(0, 1, 0, 1, 3'd0, 3'd7, 4'h0, 4'h5);
        m_txns(0, 1, 0, 1, 3'd0, 3'd7, 4'h0, 4'h5);
        n_cmp++;
        if (Rdata_B !== sb) begin n_err++; $display("FAIL iso_wr_keeps_B: got %h want %h", Rdata_B, sb); end
        sb = Rdata_B;
        run_txns(1, 0, 0, 0, 3'd0, 3'd0, 4'h0, 4'h0);
        m_txns(1, 0, 0, 0, 3'd0, 3'd0, 4'h0, 4'h0);
        n_cmp++;
        if (Rdata_A !== shadow[0]) begin n_err++; $display("FAIL iso_rd_A0: got %h want %h", Rdata_A, shadow[0]); end
        n_cmp++;
        if (Rdata_B !== sb) begin n_err++; $display("FAIL iso_B_by_A: got %h want %h", Rdata_B, sb); end
        sa = Rdata_A;
        run_txns(0, 1, 0, 0, 3'd0, 3'd7, 4'h0, 4'h0);
        m_txns(0, 1, 0, 0, 3'd0, 3'd7, 4'h0, 4'h0);
        n_cmp++;
        if (Rdata_B !== 4'h5) begin n_err++; $display("FAIL iso_rd_B7: got %h want 5", Rdata_B); end
        n_cmp++;
        if (Rdata_A !== sa) begin n_err++; $display("FAIL iso_A_by_B: got %h want %h", Rdata_A, sa); end
    endtask

    task automatic test_idle();
        int bad;
        run_txns(1, 0, 1, 0, 3'd2, 3'd0, 4'hC, 4'h0);
        m_txns(1, 0, 1, 0, 3'd2, 3'd0, 4'hC, 4'h0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            if (Rs_RW !== 1'b0 || Busy !== 1'b0 || Gnt_A !== 1'b0 || Gnt_B !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL idle_quiet: active cycles got %0d want 0", bad); end
        run_txns(1, 0, 0, 0, 3'd2, 3'd0, 4'h0, 4'h0);
        m_txns(1, 0, 0, 0, 3'd2, 3'd0, 4'h0, 4'h0);
        n_cmp++;
        if (Rdata_A !== 4'hC) begin n_err++; $display("FAIL idle_readback: got %h want c", Rdata_A); end
    endtask

    task automatic test_random();
        bit ra, rb, rwa, rwb;
        logic [AW-1:0] aa, ab;
        logic [DW-1:0] wa, wb;
        int sel;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 2);
            ra  = (sel != 1); rb = (sel != 0);
            rwa = 1'($urandom); rwb = 1'($urandom);
            aa  = AW'($urandom); ab = AW'($urandom);
            wa  = DW'($urandom); wb = DW'($urandom);
            run_txns(ra, rb, rwa, rwb, aa, ab, wa, wb);
            m_txns(ra, rb, rwa, rwb, aa, ab, wa, wb);
            n_cmp++;
            if (r_gc[0] !== e_gc[0] || r_gc[1] !== e_gc[1] || r_dc[0] !== e_dc[0] || r_dc[1] !== e_dc[1]) begin
                n_err++;
                $display("FAIL rnd%0d_timing: gnt %0d/%0d done %0d/%0d want gnt %0d/%0d done %0d/%0d",
                         it, r_gc[0], r_gc[1], r_dc[0], r_dc[1], e_gc[0], e_gc[1], e_dc[0], e_dc[1]);
            end
            n_cmp++;
            if (Rdata_A !== m_rd[0] || Rdata_B !== m_rd[1] || r_ovl !== 1'b0 || Busy !== 1'b0) begin
                n_err++;
                $display("FAIL rnd%0d_data: rdata %h/%h ovl %b busy %b want %h/%h 0 0",
                         it, Rdata_A, Rdata_B, r_ovl, Busy, m_rd[0], m_rd[1]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) shadow[i] = '0;
        m_reset();
        test_reset();
        test_write_read();
        test_tie();
        test_back_to_back();
        test_owner_isolation();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
